// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline stall/flush sequencer.
//   ctrl_state_e    : sequencer state (StRun, StMduBusy)
//   REG_ZERO        : architectural register $0, never a hazard source
//   MDU_LATENCY_DEF : default number of cycles an MDU op occupies EX
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMduBusy = 1'b1
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MDU_LATENCY_DEF = 4;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// ----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard compare between the load in EX and
// the source registers of the instruction in ID.
// Ports:
//   ex_memread_i : instruction in EX is a load
//   ex_rt_i      : destination register of the load in EX
//   id_rs_i      : rs of the instruction in ID
//   id_rt_i      : rt of the instruction in ID
//   load_use_o   : ID consumes the load result before it can be forwarded
// ----------------------------------------------------------------------------
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       load_use_o
);

  logic w_dest_valid;
  logic w_src_match;

  // A load into $0 produces nothing, so it can never stall a consumer.
  assign w_dest_valid = ex_memread_i && (ex_rt_i != REG_ZERO);
  assign w_src_match  = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);
  assign load_use_o   = w_dest_valid && w_src_match;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_stall_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Covers the hazards that
// forwarding cannot: load-use, taken-branch squash and multi-cycle MDU
// occupancy of EX. Drives the enables/flushes of PC, IF/ID, ID/EX, EX/MEM.
//
// Optional feature macro: STALL_STATS_EN
//   When defined, adds stall_cycles_o (cycles with pc_write_o=0) and
//   flush_count_o (cycles with ifid_flush_o=1), both cleared by rst_i and
//   wrapping at 2^32.
//
// Parameters:
//   MDU_LATENCY : cycles an MDU op occupies EX (2..16)
//   CNT_W       : countdown width, must hold MDU_LATENCY-1
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   id_rs_i, id_rt_i      : source registers of the instruction in ID
//   id_mdu_i              : instruction in ID is a mult/div
//   ex_rt_i, ex_memread_i : destination and load flag of the EX instruction
//   ex_branch_taken_i     : branch resolved taken in EX this cycle
//   pc_write_o, ifid_write_o, idex_write_o : register enables
//   ifid_flush_o, idex_flush_o, exmem_flush_o : bubble/zero requests
//   mdu_busy_o            : MDU sequence in progress
// ----------------------------------------------------------------------------
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_mdu_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        ex_memread_i,
  input  logic        ex_branch_taken_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_write_o,
  output logic        idex_flush_o,
  output logic        exmem_flush_o,
`ifdef STALL_STATS_EN
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o,
`endif
  output logic        mdu_busy_o
);

  // The entry cycle itself lets the op into EX, so only LATENCY-1 stall
  // cycles are counted down.
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MDU_LATENCY - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_load_use;

  load_use_detect u_load_use_detect (
    .ex_memread_i (ex_memread_i),
    .ex_rt_i      (ex_rt_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .load_use_o   (w_load_use)
  );

  // State register and countdown.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StRun;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic. cnt is only loaded on entry to StMduBusy and leaves
  // at 1, so it never underflows.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StRun: begin
        // A taken branch squashes ID, and a load-use stall holds the MDU op
        // in ID until it can issue.
        if (!ex_branch_taken_i && !w_load_use && id_mdu_i) begin
          w_state_next = StMduBusy;
          w_cnt_next   = CntLoad;
        end
      end
      StMduBusy: begin
        w_cnt_next = r_cnt - CntOne;
        if (r_cnt == CntOne) begin
          w_state_next = StRun;
        end
      end
      default: begin
        w_state_next = StRun;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output logic, combinational from state and inputs. Reset overrides at
  // once so an aborted MDU sequence releases the pipeline in the same cycle.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    mdu_busy_o    = 1'b0;
    if (!rst_i) begin
      unique case (r_state)
        StRun: begin
          if (ex_branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
          end else if (w_load_use) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
          end
        end
        StMduBusy: begin
          // EX holds the MDU op; everything upstream freezes and MEM gets
          // bubbles until the result is ready.
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_write_o  = 1'b0;
          exmem_flush_o = 1'b1;
          mdu_busy_o    = 1'b1;
        end
        default: begin
          pc_write_o = 1'b1;
        end
      endcase
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!pc_write_o) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (ifid_flush_o) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign flush_count_o  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  localparam int unsigned Lat = 4;

  // Output vector: {pc_write, ifid_write, ifid_flush, idex_write,
  //                 idex_flush, exmem_flush, mdu_busy}
  localparam logic [6:0] DEF  = 7'b1101000;
  localparam logic [6:0] LU   = 7'b0001100;
  localparam logic [6:0] BR   = 7'b1111100;
  localparam logic [6:0] BUSY = 7'b0000011;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
  logic       id_mdu_i, ex_memread_i, ex_branch_taken_i;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o;
  logic       idex_flush_o, exmem_flush_o, mdu_busy_o;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles_o, flush_count_o;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: remaining stall cycles of the current MDU op.
  int          m_busy_left = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  logic [6:0] w_obs;
  assign w_obs = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                  idex_flush_o, exmem_flush_o, mdu_busy_o};

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .MDU_LATENCY (Lat),
    .CNT_W       (4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .id_rs_i           (id_rs_i),
    .id_rt_i           (id_rt_i),
    .id_mdu_i          (id_mdu_i),
    .ex_rt_i           (ex_rt_i),
    .ex_memread_i      (ex_memread_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .pc_write_o        (pc_write_o),
    .ifid_write_o      (ifid_write_o),
    .ifid_flush_o      (ifid_flush_o),
    .idex_write_o      (idex_write_o),
    .idex_flush_o      (idex_flush_o),
    .exmem_flush_o     (exmem_flush_o),
`ifdef STALL_STATS_EN
    .stall_cycles_o    (stall_cycles_o),
    .flush_count_o     (flush_count_o),
`endif
    .mdu_busy_o        (mdu_busy_o)
  );

  function automatic logic model_hazard();
    return ex_memread_i && (ex_rt_i != 5'd0) &&
           ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  endfunction

  // Expected outputs for the current cycle from the spec's priority rules.
  function automatic logic [6:0] model_out();
    if (rst_i)                  return DEF;
    else if (m_busy_left > 0)   return BUSY;
    else if (ex_branch_taken_i) return BR;
    else if (model_hazard())    return LU;
    else                        return DEF;
  endfunction

  task automatic model_step(input logic [6:0] exp);
    if (rst_i) begin
      m_busy_left = 0;
      m_stall     = 0;
      m_flush     = 0;
    end else begin
      if (!exp[6]) m_stall = m_stall + 1;
      if (exp[4])  m_flush = m_flush + 1;
      if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
      else if (!ex_branch_taken_i && !model_hazard() && id_mdu_i)
        m_busy_left = Lat - 1;
    end
  endtask

  task automatic clear_inputs();
    id_rs_i = 5'd0; id_rt_i = 5'd0; ex_rt_i = 5'd0;
    id_mdu_i = 1'b0; ex_memread_i = 1'b0; ex_branch_taken_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    id_mdu_i = 1'b1;
    @(negedge clk);
    total++;
    if (w_obs !== DEF) begin
      bad++; $display("FAIL reset_hold obs=%b exp=%b", w_obs, DEF);
    end
    next_cycle();
    rst_i = 1'b0;
    id_mdu_i = 1'b0;
    @(negedge clk);
    total++;
    if (w_obs !== DEF) begin
      bad++; $display("FAIL reset_release obs=%b exp=%b", w_obs, DEF);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8; id_rt_i = 5'd3;
    @(negedge clk);
    total++;
    if (w_obs !== LU) begin
      bad++; $display("FAIL lu_rs obs=%b exp=%b", w_obs, LU);
    end
    next_cycle();
    ex_memread_i = 1'b0; ex_rt_i = 5'd3; id_rs_i = 5'd8;
    @(negedge clk);
    total++;
    if (w_obs !== DEF) begin
      bad++; $display("FAIL lu_clear obs=%b exp=%b", w_obs, DEF);
    end
    next_cycle();
    ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0; id_rt_i = 5'd0;
    @(negedge clk);
    total++;
    if (w_obs !== DEF) begin
      bad++; $display("FAIL lu_zero obs=%b exp=%b", w_obs, DEF);
    end
    next_cycle();
    ex_rt_i = 5'd9; id_rs_i = 5'd1; id_rt_i = 5'd9;
    @(negedge clk);
    total++;
    if (w_obs !== LU) begin
      bad++; $display("FAIL lu_rt obs=%b exp=%b", w_obs, LU);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    do_reset();
    ex_branch_taken_i = 1'b1; ex_memread_i = 1'b1;
    ex_rt_i = 5'd5; id_rt_i = 5'd5; id_mdu_i = 1'b1;
    @(negedge clk);
    total++;
    if (w_obs !== BR) begin
      bad++; $display("FAIL branch_lu obs=%b exp=%b", w_obs, BR);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    total++;
    if (w_obs !== DEF) begin
      bad++; $display("FAIL branch_no_mdu obs=%b exp=%b", w_obs, DEF);
    end
    next_cycle();
  endtask

  task automatic test_mdu();
    do_reset();
    id_mdu_i = 1'b1;
    @(negedge clk);
    total++;
    if (w_obs !== DEF) begin
      bad++; $display("FAIL mdu_issue obs=%b exp=%b", w_obs, DEF);
    end
    next_cycle();
    id_mdu_i = 1'b0;
    for (int c = 1; c < Lat; c++) begin
      // Hazards in the middle of the window must be ignored.
      ex_branch_taken_i = (c == 2);
      ex_memread_i = 1'b1; ex_rt_i = 5'd4; id_rs_i = 5'd4;
      @(negedge clk);
      total++;
      if (w_obs !== BUSY) begin
        bad++; $display("FAIL mdu_busy_c%0d obs=%b exp=%b", c, w_obs, BUSY);
      end
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    total++;
    if (w_obs !== DEF) begin
      bad++; $display("FAIL mdu_done obs=%b exp=%b", w_obs, DEF);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp;
    do_reset();
    id_mdu_i = 1'b1;
    for (int c = 0; c < 2 * Lat + 1; c++) begin
      exp = ((c % Lat) == 0) ? DEF : BUSY;
      @(negedge clk);
      total++;
      if (w_obs !== exp) begin
        bad++; $display("FAIL b2b_c%0d obs=%b exp=%b", c, w_obs, exp);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    id_mdu_i = 1'b1;
    next_cycle();
    id_mdu_i = 1'b0;
    next_cycle();
    rst_i = 1'b1;
    @(negedge clk);
    total++;
    if (w_obs !== DEF) begin
      bad++; $display("FAIL rst_mid_mdu obs=%b exp=%b", w_obs, DEF);
    end
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk);
    total++;
    if (w_obs !== DEF) begin
      bad++; $display("FAIL rst_after_mdu obs=%b exp=%b", w_obs, DEF);
    end
    next_cycle();
  endtask

`ifdef STALL_STATS_EN
  task automatic test_stats();
    do_reset();
    ex_memread_i = 1'b1; ex_rt_i = 5'd7; id_rs_i = 5'd7;
    next_cycle();
    clear_inputs();
    ex_branch_taken_i = 1'b1;
    next_cycle();
    clear_inputs();
    id_mdu_i = 1'b1;
    next_cycle();
    id_mdu_i = 1'b0;
    for (int c = 1; c < Lat; c++) next_cycle();
    @(negedge clk);
    total++;
    if (stall_cycles_o !== 32'd4) begin
      bad++; $display("FAIL stats_stall obs=%0d exp=4", stall_cycles_o);
    end
    total++;
    if (flush_count_o !== 32'd1) begin
      bad++; $display("FAIL stats_flush obs=%0d exp=1", flush_count_o);
    end
    next_cycle();
  endtask
`endif

  task automatic test_random();
    logic [6:0] exp;
    do_reset();
    m_busy_left = 0; m_stall = 0; m_flush = 0;
    for (int i = 0; i < 400; i++) begin
      rst_i             = ($urandom_range(0, 39) == 0);
      id_rs_i           = 5'($urandom_range(0, 3));
      id_rt_i           = 5'($urandom_range(0, 3));
      ex_rt_i           = 5'($urandom_range(0, 3));
      ex_memread_i      = ($urandom_range(0, 2) == 0);
      ex_branch_taken_i = ($urandom_range(0, 5) == 0);
      id_mdu_i          = ($urandom_range(0, 6) == 0);
      @(negedge clk);
      exp = model_out();
      total++;
      if (w_obs !== exp) begin
        bad++; $display("FAIL rand_%0d obs=%b exp=%b", i, w_obs, exp);
      end
      model_step(exp);
      next_cycle();
    end
    rst_i = 1'b0;
    clear_inputs();
`ifdef STALL_STATS_EN
    @(negedge clk);
    total++;
    if (stall_cycles_o !== m_stall) begin
      bad++; $display("FAIL rand_stall obs=%0d exp=%0d", stall_cycles_o, m_stall);
    end
    total++;
    if (flush_count_o !== m_flush) begin
      bad++; $display("FAIL rand_flush obs=%0d exp=%0d", flush_count_o, m_flush);
    end
`endif
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mdu();
    test_back_to_back();
    test_reset_mid_mdu();
`ifdef STALL_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
